// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-256 key schedule constants, Rcon table and FSM state type
package aes_pkg;

  localparam int NK = 8;
  localparam int NR = 14;
  localparam int NW = 60;

  // Indexed by i/8; entry 0 is never used by AES-256.
  localparam logic [7:0] RCON [8] = '{8'h00, 8'h01, 8'h02, 8'h04,
                                      8'h08, 8'h10, 8'h20, 8'h40};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } kx_state_e;

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - 8-bit combinational AES forward S-box
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y_o = SBOX[a_i];

endmodule

// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - sequential AES-256 key expansion, one word per cycle
// Optional feature macro: AES_KEYEXP_ZEROIZE_EN clears the word store on the yumi_i handshake.
module aes_key_expand_seq
  import aes_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic [255:0]  key_i,
  input  logic          key_v_i,
  output logic          ready_o,
  output logic [1919:0] key_chain_o,
  output logic          v_o,
  input  logic          yumi_i
);

  kx_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        v_q, v_d;
  logic [31:0] words_q [NW];
  logic [31:0] words_d [NW];

  logic [31:0] w_prev, w_back, sub_in, sub_out, temp, new_word;

  assign w_prev = words_q[cnt_q - 6'd1];
  assign w_back = words_q[cnt_q - 6'd8];
  assign sub_in = (cnt_q[2:0] == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .a_i (sub_in[8*b +: 8]),
      .y_o (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    temp = w_prev;
    if (cnt_q[2:0] == 3'd0) begin
      temp = sub_out ^ {RCON[cnt_q[5:3]], 24'h0};
    end else if (cnt_q[2:0] == 3'd4) begin
      temp = sub_out;
    end
  end

  assign new_word = w_back ^ temp;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    v_d     = v_q;
    words_d = words_q;
    case (state_q)
      ST_IDLE: begin
        if (key_v_i) begin
          for (int j = 0; j < NK; j++) begin
            words_d[j] = key_i[255 - 32*j -: 32];
          end
          cnt_d   = 6'd8;
          state_d = ST_EXPAND;
          ready_d = 1'b0;
        end
      end
      ST_EXPAND: begin
        words_d[cnt_q] = new_word;
        cnt_d          = cnt_q + 6'd1;
        if (cnt_q == 6'(NW - 1)) begin
          state_d = ST_DONE;
          v_d     = 1'b1;
        end
      end
      ST_DONE: begin
        if (yumi_i) begin
`ifdef AES_KEYEXP_ZEROIZE_EN
          for (int j = 0; j < NW; j++) begin
            words_d[j] = 32'h0;
          end
`endif
          state_d = ST_IDLE;
          v_d     = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        v_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      ready_q <= 1'b1;
      v_q     <= 1'b0;
      for (int j = 0; j < NW; j++) begin
        words_q[j] <= 32'h0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      v_q     <= v_d;
      words_q <= words_d;
    end
  end

  assign ready_o = ready_q;
  assign v_o     = v_q;

  // w[0] lands in the MSBs so round key 0 leads the chain.
  for (genvar j = 0; j < NW; j++) begin : g_chain
    assign key_chain_o[1919 - 32*j -: 32] = words_q[j];
  end

endmodule

// File: doc/aes_key_expand_seq.md
AES_KEY_EXPAND_SEQ -- requirements
Module: aes_key_expand_seq

Interface
REQ-001 SHALL have ports: clk_i, input, 1, sole clock, rising edge.
REQ-002 SHALL have ports: reset_n_i, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have ports: key_i, input, 256, AES-256 cipher key, sampled on accept.
REQ-004 SHALL have ports: key_v_i, input, 1, key_i valid.
REQ-005 SHALL have ports: ready_o, output, 1, block can accept a key.
REQ-006 SHALL have ports: key_chain_o, output, 1920, expanded schedule; word w[i] at bits [1919-32i -: 32], so round key 0 occupies the MSBs. This is the key_chain format consumed by the encrypt/decrypt datapath.
REQ-007 SHALL have ports: v_o, output, 1, key_chain_o complete and valid.
REQ-008 SHALL have ports: yumi_i, input, 1, consumer takes key_chain_o.
REQ-009 SHALL have no parameters; constants NK=8, NR=14, NW=60 are fixed.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, EXPAND, DONE.
REQ-011 IDLE: ready_o=1, v_o=0; on key_v_i=1 at an edge, SHALL load w[0..7] from key_i (w[0] = key_i[255:224]), set word counter i=8 and go to EXPAND.
REQ-012 EXPAND: ready_o=0, v_o=0; each edge SHALL write exactly one word w[i] = w[i-8] XOR temp, where temp = w[i-1].
REQ-013 In EXPAND, if i mod 8 = 0, temp SHALL be SubWord(RotWord(w[i-1])) XOR {Rcon[i/8],24'h0}.
REQ-014 In EXPAND, if i mod 8 = 4, temp SHALL be SubWord(w[i-1]).
REQ-015 In EXPAND, the counter SHALL increment by 1 and is 6 bits wide; the edge that writes w[59] SHALL transition to DONE.
REQ-016 Latency: accept at edge T means v_o=1 after edge T+52 (52 EXPAND cycles). The latency SHALL NOT depend on data.
REQ-017 DONE: v_o=1, ready_o=0; key_chain_o SHALL be stable; on yumi_i=1 the block SHALL go to IDLE.
REQ-018 key_v_i SHALL be ignored when ready_o=0; key_i need not be held after accept.
REQ-019 yumi_i SHALL be ignored when v_o=0.
REQ-020 A new key SHALL NOT be accepted in the same cycle as yumi_i, because ready_o=0 in DONE; earliest accept is the next edge.
REQ-021 Rcon SHALL be the values for i/8 = 1..7: 01,02,04,08,10,20,40.
REQ-022 key_chain_o SHALL be combinationally driven from the word register only, with no input-to-output combinational path.

Reset
REQ-023 On reset_n_i=0 the block SHALL go to IDLE immediately, asynchronously, from any state, aborting any expansion in progress.
REQ-024 Reset values: counter=0, all 60 words=0, ready_o=1 (once reset is released), v_o=0, key_chain_o=0.
REQ-025 Release of reset SHALL be synchronous to clk_i; the first accept is possible at the first edge after release.

Configuration
REQ-026 The macro AES_KEYEXP_ZEROIZE_EN SHALL control key-material zeroization.
REQ-027 With AES_KEYEXP_ZEROIZE_EN defined: the edge that completes the yumi_i handshake SHALL clear all 60 words to 0, so key_chain_o=0 in IDLE.
REQ-028 Without AES_KEYEXP_ZEROIZE_EN: the words SHALL retain their values after yumi_i until the next accept overwrites w[0..7].

Structure
REQ-029 The shared package aes_pkg SHALL hold: NK, NR, NW, the Rcon table, and the FSM state enum typedef.
REQ-030 The block SHALL use one sub-module, aes_sbox (8-bit combinational forward S-box), instantiated 4 times for SubWord.
REQ-031 The word store SHALL be a 60x32 flop array, implemented with no memory macro.

Verification
REQ-032 Key 000102..1f, accept -> v_o rises exactly 52 cycles later; round key 1 = 101112131415161718191a1b1c1d1e1f; round key 2 = a573c29fa176c498a97fce93a572c09c; round key 14 = 24fc79ccbf0979e9371ac23c6d68de36.
REQ-033 Key 603deb10...0914dff4 (FIPS-197 A.3) -> w[8]=9ba35411, w[59]=706c631e.
REQ-034 Pulse key_v_i during EXPAND with a different key -> pulse ignored; result equals the first key's schedule; ready_o stays 0.
REQ-035 Hold yumi_i=0 for 20 cycles in DONE -> v_o and key_chain_o stable. Then yumi_i=1 with key_v_i=1 -> the key is not taken that edge; it is taken the next edge.
REQ-036 Assert reset_n_i=0 at EXPAND cycle 30 -> immediately v_o=0 and key_chain_o=0; after release, a fresh key completes in 52 cycles.
REQ-037 With AES_KEYEXP_ZEROIZE_EN: after yumi_i, key_chain_o=0. Without it: key_chain_o is retained.
